// File: rtl/fetchalign.sv
// Fetch-alignment buffer: a circular FIFO of 16-bit parcels between fetch and Decode.
// Presents one whole 16- or 32-bit instruction per cycle, including ones that straddle fetch blocks.
module fetchalign #(
  parameter int                XLEN    = 64,
  parameter int                FETCHW  = 64,
  parameter int                DEPTH   = 8,
  parameter logic [XLEN-1:0]   RESETPC = XLEN'(64'h80000000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RedirectF,
  input  logic [XLEN-1:0]   RedirectPCF,
  input  logic              FetchValidF,
  input  logic [FETCHW-1:0] FetchDataF,
  output logic              FetchReadyF,
  input  logic              StallD,
  output logic              InstrValidD,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic              CompressedD
);

  localparam int NP  = FETCHW / 16;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int NPW = $clog2(NP);

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_next;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] head_pc;
  logic            drop_pend;
  logic [NPW-1:0]  drop_n;

  logic [15:0]     h0;
  logic [15:0]     h1;
  logic            compressed;
  logic            push;
  logic            pop;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   pop_n;

  // Handshakes: a block transfers on an edge where FetchValidF & FetchReadyF & ~RedirectF;
  // an instruction transfers where InstrValidD & ~StallD & ~RedirectF. FetchValidF without
  // FetchReadyF is ignored. Redirect (and reset) flush and override both transfers.
  always_comb begin
    rd_next     = rd_ptr + AW'(1);
    h0          = mem[rd_ptr];
    h1          = mem[rd_next];
    compressed  = ~(&h0[1:0]);
    // Count gates the decode so an empty buffer never looks valid whatever h0 holds.
    InstrValidD = (count >= CW'(2)) | ((count == CW'(1)) & compressed);
    InstrD      = compressed ? {16'b0, h0} : {h1, h0};
    CompressedD = compressed;
    PCD         = head_pc;
    FetchReadyF = (CW'(DEPTH) - count) >= CW'(NP);
  end

  always_comb begin
    // Only the first block after a redirect is trimmed; head_pc is still the target then.
    drop_n = drop_pend ? head_pc[NPW:1] : '0;
    push   = FetchValidF & FetchReadyF & ~RedirectF & ~reset;
    pop    = InstrValidD & ~StallD & ~RedirectF & ~reset;
    push_n = push ? (CW'(NP) - CW'(drop_n)) : '0;
    pop_n  = '0;
    if (pop) begin
      pop_n = compressed ? CW'(1) : CW'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_pc   <= RESETPC;
      drop_pend <= 1'b1;
    end else if (RedirectF) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_pc   <= {RedirectPCF[XLEN-1:1], 1'b0};
      drop_pend <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(push_n);
        drop_pend <= 1'b0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(pop_n);
        head_pc <= head_pc + (compressed ? XLEN'(2) : XLEN'(4));
      end
      count <= count + push_n - pop_n;
    end
  end

  // Surviving parcels are packed contiguously from wr_ptr; the index wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NP; i++) begin
        if (i >= int'(drop_n)) begin
          mem[wr_ptr + AW'(i) - AW'(drop_n)] <= FetchDataF[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_fetchalign.sv
// Directed bench for fetchalign (XLEN=64, FETCHW=64, DEPTH=8): linear steps with
// hand-computed expectations checked by immediate assertions.
module tb_fetchalign;

  logic        clk;
  logic        reset;
  logic        RedirectF;
  logic [63:0] RedirectPCF;
  logic        FetchValidF;
  logic [63:0] FetchDataF;
  logic        FetchReadyF;
  logic        StallD;
  logic        InstrValidD;
  logic [31:0] InstrD;
  logic [63:0] PCD;
  logic        CompressedD;

  int vectors;
  int miscompares;

  fetchalign #(
    .XLEN   (64),
    .FETCHW (64),
    .DEPTH  (8),
    .RESETPC(64'h80000000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RedirectF  (RedirectF),
    .RedirectPCF(RedirectPCF),
    .FetchValidF(FetchValidF),
    .FetchDataF (FetchDataF),
    .FetchReadyF(FetchReadyF),
    .StallD     (StallD),
    .InstrValidD(InstrValidD),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .CompressedD(CompressedD)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    RedirectF   = 1'b0;
    RedirectPCF = '0;
    FetchValidF = 1'b0;
    FetchDataF  = '0;
    StallD      = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_valid", InstrValidD, 0);
    chk("rst_ready", FetchReadyF, 1);
    chk("rst_pc", PCD, 64'h80000000);
    chk("rst_count", dut.count, 0);

    // First block: 4501 (16b), {0002,0003} (32b), 0001 (16b)
    FetchValidF = 1'b1;
    FetchDataF  = 64'h0001_0002_0003_4501;
    step();
    FetchValidF = 1'b0;
    chk("b1_valid", InstrValidD, 1);
    chk("b1_instr0", InstrD, 32'h0000_4501);
    chk("b1_comp0", CompressedD, 1);
    chk("b1_pc0", PCD, 64'h80000000);
    step();
    chk("b1_instr1", InstrD, 32'h0002_0003);
    chk("b1_comp1", CompressedD, 0);
    chk("b1_pc1", PCD, 64'h80000002);
    step();
    chk("b1_instr2", InstrD, 32'h0000_0001);
    chk("b1_pc2", PCD, 64'h80000006);
    step();
    chk("b1_empty", InstrValidD, 0);
    chk("b1_pc_end", PCD, 64'h80000008);

    // Redirect to 80000006 with a block offered in the same cycle (must be discarded)
    RedirectF   = 1'b1;
    RedirectPCF = 64'h80000006;
    FetchValidF = 1'b1;
    FetchDataF  = 64'h5555_5555_5555_5555;
    step();
    RedirectF   = 1'b0;
    FetchValidF = 1'b0;
    chk("rd1_valid", InstrValidD, 0);
    chk("rd1_pc", PCD, 64'h80000006);
    chk("rd1_count", dut.count, 0);
    FetchValidF = 1'b1;
    FetchDataF  = 64'h0513_AAAA_BBBB_CCCC;
    step();
    chk("straddle_hold", InstrValidD, 0);
    chk("straddle_count", dut.count, 1);
    FetchDataF = 64'h0008_000C_0014_0010;
    step();
    FetchValidF = 1'b0;
    chk("straddle_valid", InstrValidD, 1);
    chk("straddle_instr", InstrD, 32'h0010_0513);
    chk("straddle_comp", CompressedD, 0);
    chk("straddle_pc", PCD, 64'h80000006);
    chk("count5_ready", FetchReadyF, 0);

    // Fill to DEPTH under stall
    RedirectF   = 1'b1;
    RedirectPCF = 64'h80000100;
    StallD      = 1'b1;
    step();
    RedirectF   = 1'b0;
    FetchValidF = 1'b1;
    FetchDataF  = 64'h0006_0004_0002_4501;
    step();
    chk("fill4_count", dut.count, 4);
    chk("fill4_ready", FetchReadyF, 1);
    FetchDataF = 64'h0093_0008_0010_0513;
    step();
    FetchValidF = 1'b0;
    chk("fill8_count", dut.count, 8);
    chk("fill8_ready", FetchReadyF, 0);
    FetchValidF = 1'b1;
    FetchDataF  = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    FetchValidF = 1'b0;
    chk("viol_count", dut.count, 8);
    chk("viol_wrptr", dut.wr_ptr, 0);
    chk("viol_instr", InstrD, 32'h0000_4501);
    chk("viol_pc", PCD, 64'h80000100);

    // Drain the all-compressed block, one per cycle
    StallD = 1'b0;
    step();
    chk("drain_instr1", InstrD, 32'h0000_0002);
    chk("drain_count1", dut.count, 7);
    step();
    step();
    chk("drain_instr3", InstrD, 32'h0000_0006);
    chk("drain_pc3", PCD, 64'h80000106);
    step();
    chk("c4_count", dut.count, 4);
    chk("c4_instr", InstrD, 32'h0010_0513);
    chk("c4_pc", PCD, 64'h80000108);
    chk("c4_ready", FetchReadyF, 1);

    // Push and 32-bit pop in the same cycle
    FetchValidF = 1'b1;
    FetchDataF  = 64'h0014_0010_000C_00F0;
    step();
    FetchValidF = 1'b0;
    chk("pp_count", dut.count, 6);
    chk("pp_pc", PCD, 64'h8000010C);
    chk("pp_instr", InstrD, 32'h0000_0008);
    step();
    chk("wrap_rdptr", dut.rd_ptr, 7);
    chk("wrap_count", dut.count, 5);
    chk("wrap_instr", InstrD, 32'h00F0_0093);
    chk("wrap_comp", CompressedD, 0);
    chk("wrap_pc", PCD, 64'h8000010E);
    step();
    chk("wrap_rdptr_after", dut.rd_ptr, 1);
    chk("wrap_count_after", dut.count, 3);
    chk("wrap_pc_after", PCD, 64'h80000112);
    chk("wrap_instr_after", InstrD, 32'h0000_000C);

    // Redirect together with push and pop; odd target bit 0 is ignored
    FetchValidF = 1'b1;
    FetchDataF  = 64'h4445_4445_4445_4445;
    RedirectF   = 1'b1;
    RedirectPCF = 64'h80001001;
    step();
    RedirectF   = 1'b0;
    FetchValidF = 1'b0;
    chk("rpp_count", dut.count, 0);
    chk("rpp_valid", InstrValidD, 0);
    chk("rpp_pc", PCD, 64'h80001000);
    FetchValidF = 1'b1;
    FetchDataF  = 64'h0020_001C_0018_1234;
    step();
    FetchValidF = 1'b0;
    chk("rpp_new_instr", InstrD, 32'h0000_1234);
    chk("rpp_new_count", dut.count, 4);
    chk("rpp_new_pc", PCD, 64'h80001000);

    // PC wrap at the top of the address space
    RedirectF   = 1'b1;
    RedirectPCF = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    RedirectF   = 1'b0;
    FetchValidF = 1'b1;
    FetchDataF  = 64'h0001_7777_7777_7777;
    step();
    FetchValidF = 1'b0;
    chk("top_valid", InstrValidD, 1);
    chk("top_instr", InstrD, 32'h0000_0001);
    chk("top_pc", PCD, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("top_count", dut.count, 1);
    step();
    chk("top_empty", InstrValidD, 0);
    chk("top_pc_wrap", PCD, 64'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
